// File: rtl/m6809_pkg.sv
// Shared types for the 6809 bus arbiter: ownership states, BA/BS status codes and the state->pin decode.
// Pure declarations; no latency or backpressure of its own.
package m6809_pkg;

    localparam int MAX_STEAL_DEF = 14;
    localparam int CNT_W_DEF     = 4;

    typedef enum logic [3:0] {
        ST_RST,
        ST_RUN,
        ST_DEAD_IN,
        ST_DMA,
        ST_DEAD_OUT,
        ST_FORCE,
        ST_HALTED,
        ST_HDEAD_IN,
        ST_HDMA,
        ST_HDEAD_OUT
    } arb_state_e;

    // {ba, bs} as the 6809 drives them.
    localparam logic [1:0] BABS_RUN        = 2'b00;
    localparam logic [1:0] BABS_IRQ_ACK    = 2'b01;
    localparam logic [1:0] BABS_SYNC_ACK   = 2'b10;
    localparam logic [1:0] BABS_HALT_GRANT = 2'b11;

    typedef struct packed {
        logic       cpu_hold;
        logic       dma_grant;
        logic [1:0] babs;
        logic       dead_cycle;
    } arb_out_t;

    function automatic arb_out_t state_outputs(input arb_state_e st);
        arb_out_t o;
        o = '{cpu_hold: 1'b1, dma_grant: 1'b0, babs: BABS_HALT_GRANT, dead_cycle: 1'b0};
        case (st)
            ST_RST: begin
                o.babs = BABS_IRQ_ACK;
            end
            ST_RUN, ST_FORCE: begin
                o.cpu_hold = 1'b0;
                o.babs     = BABS_RUN;
            end
            ST_DEAD_IN, ST_DEAD_OUT, ST_HDEAD_IN, ST_HDEAD_OUT: begin
                o.dead_cycle = 1'b1;
            end
            ST_DMA, ST_HDMA: begin
                o.dma_grant = 1'b1;
            end
            default: begin
                o.cpu_hold = 1'b1;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/m6809_bus_arbiter.sv
// Hands the 6809 system bus between core and one DMA master with a dead cycle each way; Moore outputs one edge after the deciding input.
// DMA bursts with the CPU running are capped at MAX_STEAL cycles; the core is held off via cpu_hold rather than by backpressure.
module m6809_bus_arbiter
    import m6809_pkg::*;
#(
    parameter int MAX_STEAL = MAX_STEAL_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             halt_b,
    input  logic             dma_breq,
    input  logic             cpu_cycle_end,
    input  logic             cpu_inst_end,
    output logic             cpu_hold,
    output logic             dma_grant,
    output logic             ba,
    output logic             bs,
    output logic             dead_cycle,
    output logic [CNT_W-1:0] steal_cnt
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEAL);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             force_q, force_d;
    arb_out_t         outs_q, outs_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        force_d = force_q;
        case (state_q)
            ST_RST: begin
                state_d = ST_RUN;
            end
            ST_RUN, ST_FORCE: begin
                // A forced CPU cycle must complete before ownership may move again.
                if (state_q == ST_RUN || cpu_cycle_end) begin
                    force_d = 1'b0;
                    if (dma_breq && cpu_cycle_end) begin
                        state_d = ST_DEAD_IN;
                        cnt_d   = '0;
                    end else if (!halt_b && cpu_inst_end) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_DEAD_IN: begin
                state_d = ST_DMA;
                cnt_d   = ONE_CNT;
            end
            ST_DMA: begin
                if (!dma_breq) begin
                    state_d = ST_DEAD_OUT;
                end else if (cnt_q == MAX_CNT) begin
                    state_d = ST_DEAD_OUT;
                    force_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE_CNT;
                end
            end
            ST_DEAD_OUT: begin
                state_d = force_q ? ST_FORCE : ST_RUN;
            end
            ST_HALTED: begin
                if (dma_breq) begin
                    state_d = ST_HDEAD_IN;
                    cnt_d   = '0;
                end else if (halt_b) begin
                    state_d = ST_RUN;
                end
            end
            ST_HDEAD_IN: begin
                state_d = ST_HDMA;
                cnt_d   = ONE_CNT;
            end
            ST_HDMA: begin
                // Core is halted anyway, so no steal limit; the counter just saturates.
                if (!dma_breq) begin
                    state_d = ST_HDEAD_OUT;
                end else if (cnt_q != MAX_CNT) begin
                    cnt_d = cnt_q + ONE_CNT;
                end
            end
            ST_HDEAD_OUT: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RST;
                cnt_d   = '0;
                force_d = 1'b0;
            end
        endcase
        outs_d = state_outputs(state_d);
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_q <= ST_RST;
            cnt_q   <= '0;
            force_q <= 1'b0;
            outs_q  <= state_outputs(ST_RST);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            force_q <= force_d;
            outs_q  <= outs_d;
        end
    end

    assign cpu_hold   = outs_q.cpu_hold;
    assign dma_grant  = outs_q.dma_grant;
    assign ba         = outs_q.babs[1];
    assign bs         = outs_q.babs[0];
    assign dead_cycle = outs_q.dead_cycle;
    assign steal_cnt  = cnt_q;

endmodule

// File: tb/tb_m6809_bus_arbiter.sv
// Bench for m6809_bus_arbiter: fixed vectors, hand-written corner sequences and random traffic against a behavioural model.
module tb_m6809_bus_arbiter;

    localparam int MAX = 14;
    localparam int M_CPU = 0, M_DIN = 1, M_DMA = 2, M_DOUT = 3;

    logic       clk = 1'b0;
    logic       reset_b, halt_b, dma_breq, cpu_cycle_end, cpu_inst_end;
    logic       cpu_hold, dma_grant, ba, bs, dead_cycle;
    logic [3:0] steal_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    m6809_bus_arbiter #(.MAX_STEAL(MAX), .CNT_W(4)) dut (
        .clk(clk), .reset_b(reset_b), .halt_b(halt_b), .dma_breq(dma_breq),
        .cpu_cycle_end(cpu_cycle_end), .cpu_inst_end(cpu_inst_end),
        .cpu_hold(cpu_hold), .dma_grant(dma_grant), .ba(ba), .bs(bs),
        .dead_cycle(dead_cycle), .steal_cnt(steal_cnt)
    );

    always #5 clk = ~clk;

    // {hold, grant, ba, bs, dead, cnt[3:0]}
    wire [8:0] dut_out = {cpu_hold, dma_grant, ba, bs, dead_cycle, steal_cnt};

    // Behavioural model: who owns the bus, whether the CPU is parked by halt, and a pending forced CPU cycle.
    bit m_rst    = 1'b1;
    bit m_halted = 1'b0;
    bit m_force  = 1'b0;
    int m_mode   = M_CPU;
    int m_cnt    = 0;

    task automatic model_step();
        if (!reset_b) begin
            m_rst = 1; m_mode = M_CPU; m_halted = 0; m_force = 0; m_cnt = 0;
        end else if (m_rst) begin
            m_rst = 0;
        end else begin
            case (m_mode)
                M_CPU: begin
                    if (m_halted) begin
                        if (dma_breq) begin m_mode = M_DIN; m_cnt = 0; end
                        else if (halt_b) m_halted = 0;
                    end else if (!m_force || cpu_cycle_end) begin
                        m_force = 0;
                        if (dma_breq && cpu_cycle_end) begin m_mode = M_DIN; m_cnt = 0; end
                        else if (!halt_b && cpu_inst_end) m_halted = 1;
                    end
                end
                M_DIN: begin m_mode = M_DMA; m_cnt = 1; end
                M_DMA: begin
                    if (!dma_breq) m_mode = M_DOUT;
                    else if (!m_halted && m_cnt == MAX) begin m_mode = M_DOUT; m_force = 1; end
                    else m_cnt = (m_cnt < MAX) ? m_cnt + 1 : MAX;
                end
                default: m_mode = M_CPU;
            endcase
        end
    endtask

    function automatic logic [8:0] model_exp();
        logic [4:0] pins;
        if (m_rst) return 9'b10010_0000;
        case (m_mode)
            M_CPU:   pins = m_halted ? 5'b10110 : 5'b00000;
            M_DMA:   pins = 5'b11110;
            default: pins = 5'b10111;
        endcase
        return {pins, 4'(m_cnt)};
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Inputs change at the falling edge; the model advances on the rising edge with the same values the DUT sees.
    task automatic cycle(input logic rb, input logic hb, input logic br, input logic ce, input logic ie);
        reset_b = rb; halt_b = hb; dma_breq = br; cpu_cycle_end = ce; cpu_inst_end = ie;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic cyc_m(input string name, input logic rb, input logic hb, input logic br,
                         input logic ce, input logic ie);
        cycle(rb, hb, br, ce, ie);
        check(name, dut_out, model_exp());
    endtask

    typedef struct {
        logic       rb, hb, br, ce, ie;
        logic [8:0] exp;
    } vec_t;

    vec_t vec[16];

    initial begin
        int run, runs_done, cpu_seen;
        logic br_r;

        vec[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'b10010_0000};
        vec[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'b10010_0000};
        vec[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'b00000_0000};
        vec[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 9'b10111_0000};
        vec[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'b11110_0001};
        vec[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'b11110_0010};
        vec[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'b11110_0011};
        vec[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'b10111_0011};
        vec[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'b00000_0011};
        vec[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'b00000_0011};
        vec[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 9'b10110_0011};
        vec[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'b10111_0000};
        vec[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'b11110_0001};
        vec[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'b10111_0001};
        vec[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'b10110_0001};
        vec[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'b00000_0001};

        reset_b = 1'b0; halt_b = 1'b1; dma_breq = 1'b0; cpu_cycle_end = 1'b0; cpu_inst_end = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            cycle(vec[i].rb, vec[i].hb, vec[i].br, vec[i].ce, vec[i].ie);
            check($sformatf("vec%0d", i), dut_out, vec[i].exp);
        end

        // Held request: bursts of exactly MAX grants separated by at least one CPU cycle.
        run = 0; runs_done = 0; cpu_seen = 0;
        for (int i = 0; i < 60; i++) begin
            cyc_m("burst", 1, 1, 1, 1, 0);
            if (dma_grant) begin
                if (run == 0 && runs_done > 0) check("cpu_between_bursts", 9'(cpu_seen > 0), 9'd1);
                run++;
            end else begin
                if (run > 0) begin
                    check("burst_len", 9'(run), 9'(MAX));
                    runs_done++;
                    cpu_seen = 0;
                end
                run = 0;
                if (!cpu_hold) cpu_seen++;
            end
        end
        check("bursts_seen", 9'(runs_done >= 3), 9'd1);
        for (int i = 0; i < 4; i++) cyc_m("drain", 1, 1, 0, 1, 0);

        // Forced CPU cycle waits for cycle_end even with DMA still requesting.
        cyc_m("force_in", 1, 1, 1, 1, 0);
        for (int i = 0; i < 15; i++) cyc_m("force_dma", 1, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc_m("force_wait", 1, 1, 1, 0, 0);
            check("force_hold", dut_out, 9'b00000_1110);
        end
        cyc_m("force_regrant", 1, 1, 1, 1, 0);
        check("force_regrant_dead", dut_out, 9'b10111_0000);
        for (int i = 0; i < 4; i++) cyc_m("drain", 1, 1, 0, 1, 0);

        // DMA and halt on the same edge: DMA first, halt at the next instruction end.
        cycle(1, 0, 1, 1, 1);
        check("prio_dma_first", dut_out, 9'b10111_0000);
        cyc_m("prio_dma", 1, 0, 0, 0, 0);
        cyc_m("prio_out", 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        check("prio_back_run", dut_out, 9'b00000_0001);
        cyc_m("prio_no_ie", 1, 0, 0, 1, 0);
        cycle(1, 0, 0, 1, 1);
        check("prio_halted", dut_out, 9'b10110_0001);

        // While halted, a long DMA request is one unbroken grant.
        run = 0;
        for (int i = 0; i < 31; i++) begin
            cyc_m("hdma", 1, 0, 1, 0, 0);
            if (dma_grant) run++;
        end
        check("hdma_len", 9'(run), 9'd30);
        cyc_m("hdma_out", 1, 0, 0, 0, 0);
        cyc_m("hdma_halted", 1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        check("halt_release", dut_out, 9'b00000_1110);

        // Reset in the middle of a burst.
        cyc_m("rst_din", 1, 1, 1, 1, 0);
        for (int i = 0; i < 5; i++) cyc_m("rst_dma", 1, 1, 1, 0, 0);
        check("rst_cnt5", dut_out, 9'b11110_0101);
        cycle(0, 1, 1, 0, 0);
        check("rst_midburst", dut_out, 9'b10010_0000);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 0, 1, 0);
            check("rst_hold", dut_out, 9'b10010_0000);
        end
        cycle(1, 1, 0, 0, 0);
        check("rst_release", dut_out, 9'b00000_0000);

        // Random traffic against the model.
        br_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic rb, hb, ce, ie;
            rb = ($urandom_range(0, 199) != 0);
            hb = ($urandom_range(0, 9) > 2);
            if ($urandom_range(0, 9) == 0) br_r = ~br_r;
            ce = 1'($urandom_range(0, 1));
            ie = ce & ($urandom_range(0, 3) == 0);
            cyc_m("random", rb, hb, br_r, ce, ie);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
